// File: rtl/spi_prog_loader.sv
// SPI master that streams a PLC program into program_memory as header, data words
// and checksum, then compares the checksum the target returns on MISO.
module spi_prog_loader #(
  parameter int PM_ADDR_W = 8,
  parameter int SCK_DIV   = 8
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_resetn,
  input  logic                 start,
  input  logic [PM_ADDR_W-1:0] prog_len,
  input  logic                 src_valid,
  input  logic [31:0]          src_data,
  output logic                 src_ready,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          rx_checksum
);

  // state  | meaning
  // IDLE   | wait for start      SHIFT | 32 bit cells        GAP    | target settle time
  // FETCH  | await source word   TAIL  | trailing bit cell   FINISH | report pass, pulse done
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_GAP, S_FETCH, S_TAIL, S_FINISH} state_t;
  typedef enum logic [1:0] {K_HDR, K_DATA, K_CSUM} kind_t;

  localparam int DIV_W = $clog2(2 * SCK_DIV);
  localparam logic [DIV_W-1:0]   HALF_M1 = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0]   GAP_M1  = DIV_W'(2 * SCK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE = DIV_W'(1);
  localparam logic [PM_ADDR_W:0] WC_ONE  = (PM_ADDR_W + 1)'(1);

  state_t               state_q, state_d;
  kind_t                kind_q, kind_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [5:0]           bits_left_q, bits_left_d;
  logic [PM_ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [31:0]          shreg_q, shreg_d;
  logic [31:0]          csum_q, csum_d;
  logic [31:0]          rx_q, rx_d;
  logic                 sck_q, sck_d;
  logic                 mosi_q, mosi_d;
  logic                 src_ready_q, src_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    div_cnt_d   = div_cnt_q;
    bits_left_d = bits_left_q;
    word_cnt_d  = word_cnt_q;
    shreg_d     = shreg_q;
    csum_d      = csum_q;
    rx_d        = rx_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    src_ready_d = src_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          word_cnt_d  = {1'b0, prog_len} + WC_ONE;
          csum_d      = '0;
          shreg_d     = 32'(prog_len);
          bits_left_d = 6'd32;
          div_cnt_d   = '0;
          kind_d      = K_HDR;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT, S_TAIL: begin
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end else if (!sck_q) begin
          sck_d     = 1'b1;
          div_cnt_d = HALF_M1;
          // Checksum bits arrive LSB first, so shift in from the top.
          if (state_q == S_SHIFT && kind_q == K_CSUM) rx_d = {spi_miso, rx_q[31:1]};
        end else if (bits_left_q != 6'd0) begin
          sck_d       = 1'b0;
          mosi_d      = shreg_q[0];
          shreg_d     = {1'b1, shreg_q[31:1]};
          bits_left_d = bits_left_q - 6'd1;
          div_cnt_d   = HALF_M1;
        end else if (state_q == S_TAIL) begin
          state_d = S_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (rx_q == csum_q);
        end else begin
          state_d   = S_GAP;
          div_cnt_d = GAP_M1;
        end
      end
      S_GAP: begin
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end else if (kind_q == K_CSUM) begin
          shreg_d     = '1;
          bits_left_d = 6'd1;
          state_d     = S_TAIL;
        end else if (kind_q == K_DATA && word_cnt_q == '0) begin
          shreg_d     = csum_q;
          bits_left_d = 6'd32;
          kind_d      = K_CSUM;
          state_d     = S_SHIFT;
        end else begin
          src_ready_d = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (src_valid && src_ready_q) begin
          src_ready_d = 1'b0;
          shreg_d     = src_data;
          csum_d      = csum_q + src_data;
          word_cnt_d  = word_cnt_q - WC_ONE;
          bits_left_d = 6'd32;
          div_cnt_d   = '0;
          kind_d      = K_DATA;
          state_d     = S_SHIFT;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q     <= S_IDLE;
      kind_q      <= K_HDR;
      div_cnt_q   <= '0;
      bits_left_q <= '0;
      word_cnt_q  <= '0;
      shreg_q     <= '0;
      csum_q      <= '0;
      rx_q        <= '0;
      sck_q       <= 1'b1;
      mosi_q      <= 1'b1;
      src_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      div_cnt_q   <= div_cnt_d;
      bits_left_q <= bits_left_d;
      word_cnt_q  <= word_cnt_d;
      shreg_q     <= shreg_d;
      csum_q      <= csum_d;
      rx_q        <= rx_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      src_ready_q <= src_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign spi_sck     = sck_q;
  assign spi_mosi    = mosi_q;
  assign src_ready   = src_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign rx_checksum = rx_q;

endmodule

// File: doc/spi_prog_loader.md
# spi_prog_loader

SPI master that downloads a PLC program into the `program_memory` block over its SPI programming port (`spi_sck`/`spi_mosi`/`spi_miso`) and then runs the checksum handshake that releases the CPU. It takes program words from an upstream 32-bit valid/ready stream, such as the HMI link or a boot ROM reader. It frames them as header, data words and checksum word, and reports pass/fail from the checksum returned on MISO.

## Interface
- `PM_ADDR_W`, 8, program memory address width; must match `program_memory`.
- `SCK_DIV`, 8, `cpu_clk` cycles per SCK half-period; legal values are 8 or more.
- `cpu_clk`  in  1  clock.
- `cpu_resetn`  in  1  reset; asynchronous, active-low. Clock is `cpu_clk`.
- `start`  in  1  one-cycle request to begin a download; ignored while `busy`.
- `prog_len`  in  PM_ADDR_W  last program address N; N+1 words are sent. Latched on accepted `start`.
- `src_valid`  in  1  upstream word valid.
- `src_data`  in  32  upstream program word.
- `src_ready`  out  1  word accepted when `src_valid & src_ready`.
- `spi_sck`  out  1  serial clock; idles high.
- `spi_mosi`  out  1  serial data to target, LSB first.
- `spi_miso`  in  1  checksum bits from target.
- `busy`  out  1  download in progress.
- `done`  out  1  one-cycle pulse at end of download.
- `pass`  out  1  level; 1 = returned checksum equals local checksum. Valid from `done` until next `start`.
- `rx_checksum`  out  32  checksum word captured from MISO.

## Operation
- Frame: header word, then N+1 data words, then the checksum word, then one trailing SCK falling/rising edge.
  - Header word is {zeros, N}.
  - Data words land at target addresses N down to 0, so the first source word belongs to address N.
  - The checksum word is the sum mod 2^32 of all accepted data words.
- Bit cell:
  - SCK falls and `spi_mosi` takes bit k (k = 0..31) in the same cycle.
  - SCK stays low for SCK_DIV cycles, then rises and stays high for SCK_DIV cycles.
  - The target samples on the rising edge.
- MISO: during the checksum word, `spi_miso` is sampled on the `cpu_clk` where SCK rises. The sample from bit cell k goes to `rx_checksum[k]`.
- Tail: one extra bit cell with `spi_mosi`=1. Its MISO sample is discarded.
- FSM states:
  - IDLE: `start` → latch N, clear checksum and word counter → SHIFT with the header.
  - SHIFT: 32 bit cells → GAP.
  - GAP: 2·SCK_DIV cycles, SCK high. Then the next state depends on what was just shifted:
    - header, or a data word other than the last → FETCH;
    - last data word → SHIFT with the checksum word;
    - checksum word → TAIL.
  - FETCH: `src_ready`=1. On handshake, load the shift register, add `src_data` to the checksum → SHIFT.
  - TAIL: 1 bit cell → FINISH.
  - FINISH: `pass` ← (`rx_checksum` == local checksum), pulse `done`, clear `busy` → IDLE.
- Source stall: FETCH waits indefinitely with SCK high and `spi_mosi` holding its last value. The target is edge-driven, so a stall is legal.
- Width rules:
  - Word counter is PM_ADDR_W+1 bits, so N = 2^PM_ADDR_W−1 does not overflow.
  - Checksum addition wraps mod 2^32.
- Retry: a failed download (`pass`=0) cannot be retried without resetting the target, because the target does not clear its checksum accumulator. This block imposes no retry policy.

## Timing
- Reset values: `spi_sck`=1, `spi_mosi`=1, `src_ready`=0, `busy`=0, `done`=0, `pass`=0, `rx_checksum`=0, state IDLE.
- `busy` rises the cycle after an accepted `start`. The first SCK fall follows one cycle later.
- `src_ready` is asserted only in FETCH and drops the cycle after the handshake. At most one word is accepted per FETCH.
- Total SCK falling edges per download: 32·(N+3)+1.
- Why the GAP and SCK_DIV ≥ 8 are required by the target:
  - The target's SCK synchroniser plus its MISO register add about 5 cycles before MISO is valid.
  - The target also needs about 7 cycles after its final data bit to enter checksum verification before the next SCK fall.
- `start` arriving in the same cycle as `done` is ignored.
- `cpu_resetn` asserted mid-download returns all outputs to their reset values immediately and asynchronously.

## Test plan
- N=0, one word 0x12345678, MISO model echoes the target checksum:
  - MOSI carries 0x00000000, 0x12345678, 0x12345678, then a tail;
  - 97 SCK falls; `done` pulses once; `pass`=1.
- N=3, words 0xFFFFFFFF, 1, 2, 3 → checksum word 0x00000005 (wraps), sent LSB first; `rx_checksum`=0x00000005; `pass`=1.
- Same as the previous case, but the MISO model returns checksum XOR 1 → `rx_checksum`=0x00000004, `pass`=0, `done` still pulses.
- `src_valid` held low for 50 cycles before word 2 → `spi_sck` stays high with no edges during the stall; the MOSI bit stream is identical to the unstalled run.
- Integration with `program_memory`, N=2, words A, B, C:
  - target array holds [2]=A, [1]=B, [0]=C;
  - target CPU run flag set; `pass`=1.
- Protocol robustness:
  - `start` pulsed while `busy` → ignored, frame unchanged;
  - `cpu_resetn` dropped mid-word → `spi_sck`=1, `spi_mosi`=1, `busy`=0 without a clock edge;
  - SCK half-period measures exactly SCK_DIV cycles.
